// File: rtl/hazard_flag_gen.sv
// Issue side of the hazard interface: a 3-slot ID/EX/MEM pipeline model that raises
// hazard flags for the hazard-control FSM and obeys its freeze/flush commands.
module hazard_flag_gen #(
  parameter int unsigned REG_AW = 3,
  parameter bit          FWD_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [REG_AW-1:0] instr_rd,
  input  logic [REG_AW-1:0] instr_rs1,
  input  logic [REG_AW-1:0] instr_rs2,
  input  logic              instr_is_load,
  input  logic              instr_uses_port,
  input  logic              instr_is_branch,
  input  logic              instr_pred_taken,
  input  logic              br_actual_taken,
  input  logic              pc_freeze,
  input  logic              do_flush,
  input  logic              resolved,
  output logic              instr_ready,
  output logic [5:0]        hz_flags,
  output logic [7:0]        retire_count,
  output logic [3:0]        flush_count
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              is_load;
    logic              uses_port;
    logic              is_branch;
    logic              pred_taken;
  } slot_t;

  slot_t      id_q, id_d, ex_q, ex_d, mem_q, mem_d;
  slot_t      new_instr;
  logic [7:0] retire_q, retire_d;
  logic [3:0] flush_q, flush_d;

  // The FSM's resolved indication is observational only.
  logic unused_resolved;
  assign unused_resolved = resolved;

  assign instr_ready = !pc_freeze && !do_flush;

  always_comb begin
    new_instr.valid      = instr_valid;
    new_instr.rd         = instr_rd;
    new_instr.rs1        = instr_rs1;
    new_instr.rs2        = instr_rs2;
    new_instr.is_load    = instr_is_load;
    new_instr.uses_port  = instr_uses_port;
    new_instr.is_branch  = instr_is_branch;
    new_instr.pred_taken = instr_pred_taken;
  end

  always_comb begin
    id_d     = id_q;
    ex_d     = ex_q;
    mem_d    = ex_q;
    retire_d = retire_q + {7'd0, mem_q.valid};
    flush_d  = flush_q;
    if (do_flush) begin
      // MEM still retires its occupant but does not receive the squashed EX slot.
      id_d  = '0;
      ex_d  = '0;
      mem_d = '0;
      if (flush_q != 4'hF) begin
        flush_d = flush_q + 4'd1;
      end
    end else if (pc_freeze) begin
      ex_d = '0;
    end else begin
      id_d = new_instr;
      ex_d = id_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_q     <= '0;
      ex_q     <= '0;
      mem_q    <= '0;
      retire_q <= '0;
      flush_q  <= '0;
    end else begin
      id_q     <= id_d;
      ex_q     <= ex_d;
      mem_q    <= mem_d;
      retire_q <= retire_d;
      flush_q  <= flush_d;
    end
  end

  logic match_ex, match_mem;
  logic data_hz, fwrd_hz, str_hz, ctrl_hz, branch_hz, crct_hz;

  always_comb begin
    match_ex  = ex_q.valid && id_q.valid && (ex_q.rd != '0) &&
                ((ex_q.rd == id_q.rs1) || (ex_q.rd == id_q.rs2));
    match_mem = mem_q.valid && id_q.valid && (mem_q.rd != '0) &&
                ((mem_q.rd == id_q.rs1) || (mem_q.rd == id_q.rs2));
    data_hz   = match_ex || match_mem;
    // A load in EX has no result yet, so load-use can never be forwarded.
    fwrd_hz   = FWD_EN && data_hz && !(match_ex && ex_q.is_load);
    str_hz    = id_q.valid && id_q.uses_port && mem_q.valid && mem_q.uses_port;
    ctrl_hz   = id_q.valid && id_q.is_branch;
    branch_hz = ex_q.valid && ex_q.is_branch;
    crct_hz   = branch_hz && (ex_q.pred_taken == br_actual_taken);
  end

  assign hz_flags     = {data_hz, str_hz, ctrl_hz, branch_hz, fwrd_hz, crct_hz};
  assign retire_count = retire_q;
  assign flush_count  = flush_q;

endmodule

// File: tb/tb_hazard_flag_gen.sv
// Bench for hazard_flag_gen: directed scenarios plus randomized traffic checked against
// a slot-list reference model; a second instance has forwarding disabled.
module tb_hazard_flag_gen;

  logic       clk;
  logic       rst_n;
  logic       instr_valid;
  logic [2:0] instr_rd, instr_rs1, instr_rs2;
  logic       instr_is_load, instr_uses_port, instr_is_branch, instr_pred_taken;
  logic       br_actual_taken, pc_freeze, do_flush, resolved;
  logic       ready_f, ready_n;
  logic [5:0] flags_f, flags_n;
  logic [7:0] retire_f, retire_n;
  logic [3:0] flush_f, flush_n;

  int checks = 0;
  int errors = 0;

  hazard_flag_gen #(.REG_AW(3), .FWD_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_rd(instr_rd),
    .instr_rs1(instr_rs1), .instr_rs2(instr_rs2), .instr_is_load(instr_is_load),
    .instr_uses_port(instr_uses_port), .instr_is_branch(instr_is_branch),
    .instr_pred_taken(instr_pred_taken), .br_actual_taken(br_actual_taken),
    .pc_freeze(pc_freeze), .do_flush(do_flush), .resolved(resolved),
    .instr_ready(ready_f), .hz_flags(flags_f), .retire_count(retire_f),
    .flush_count(flush_f)
  );

  hazard_flag_gen #(.REG_AW(3), .FWD_EN(1'b0)) dut_nofwd (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_rd(instr_rd),
    .instr_rs1(instr_rs1), .instr_rs2(instr_rs2), .instr_is_load(instr_is_load),
    .instr_uses_port(instr_uses_port), .instr_is_branch(instr_is_branch),
    .instr_pred_taken(instr_pred_taken), .br_actual_taken(br_actual_taken),
    .pc_freeze(pc_freeze), .do_flush(do_flush), .resolved(resolved),
    .instr_ready(ready_n), .hz_flags(flags_n), .retire_count(retire_n),
    .flush_count(flush_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: pipe[0]=ID, pipe[1]=EX, pipe[2]=MEM; totals kept as plain integers.
  typedef struct {
    bit v;
    int rd, rs1, rs2;
    bit ld, port, br, pt;
  } m_slot_t;

  m_slot_t pipe[3];
  int      retired = 0;
  int      flushes = 0;

  task automatic clear_model();
    for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0, 0, 0, 0, 0};
    retired = 0;
    flushes = 0;
  endtask

  // Advance one clock; the model consumes the inputs that were stable before the edge.
  task automatic cycle();
    m_slot_t incoming;
    @(posedge clk);
    incoming = '{instr_valid, int'(instr_rd), int'(instr_rs1), int'(instr_rs2),
                 instr_is_load, instr_uses_port, instr_is_branch, instr_pred_taken};
    if (!rst_n) begin
      clear_model();
    end else begin
      if (pipe[2].v) retired++;
      if (do_flush) begin
        for (int i = 0; i < 3; i++) pipe[i].v = 0;
        flushes++;
      end else if (pc_freeze) begin
        pipe[2] = pipe[1];
        pipe[1].v = 0;
      end else begin
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = incoming;
      end
    end
    #1;
  endtask

  function automatic logic [5:0] exp_flags(bit fwd_en);
    bit mex, mmem, data, fw, str, ctrl, brn, crct;
    mex  = pipe[1].v && pipe[0].v && pipe[1].rd != 0 &&
           (pipe[1].rd == pipe[0].rs1 || pipe[1].rd == pipe[0].rs2);
    mmem = pipe[2].v && pipe[0].v && pipe[2].rd != 0 &&
           (pipe[2].rd == pipe[0].rs1 || pipe[2].rd == pipe[0].rs2);
    data = mex || mmem;
    fw   = fwd_en && data && !(mex && pipe[1].ld);
    str  = pipe[0].v && pipe[0].port && pipe[2].v && pipe[2].port;
    ctrl = pipe[0].v && pipe[0].br;
    brn  = pipe[1].v && pipe[1].br;
    crct = brn && (pipe[1].pt == br_actual_taken);
    return {data, str, ctrl, brn, fw, crct};
  endfunction

  task automatic set_instr(bit v, int rd, int rs1, int rs2, bit ld, bit port, bit br, bit pt);
    instr_valid      = v;
    instr_rd         = 3'(rd);
    instr_rs1        = 3'(rs1);
    instr_rs2        = 3'(rs2);
    instr_is_load    = ld;
    instr_uses_port  = port;
    instr_is_branch  = br;
    instr_pred_taken = pt;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pc_freeze = 1'b0;
    do_flush = 1'b0;
    set_instr(0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    set_instr(1, 5, 5, 5, 1, 1, 1, 1);
    cycle();
    cycle();
    do_flush = 1'b1;
    cycle();
    do_flush = 1'b0;
    cycle();
    rst_n = 1'b0;
    cycle();
    cycle();
    checks++;
    if (flags_f !== 6'b000000) begin
      errors++; $display("FAIL reset_flags: got %b expected 000000", flags_f);
    end
    checks++;
    if (retire_f !== 8'd0 || flush_f !== 4'd0) begin
      errors++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", retire_f, flush_f);
    end
    checks++;
    if (ready_f !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b expected 1", ready_f);
    end
    rst_n = 1'b1;
    set_instr(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_fwd_raw();
    do_reset();
    set_instr(1, 3, 0, 0, 0, 0, 0, 0);
    cycle();
    set_instr(1, 0, 3, 0, 0, 0, 0, 0);
    cycle();
    set_instr(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (flags_f !== 6'b100010) begin
      errors++; $display("FAIL raw_fwd: got %b expected 100010", flags_f);
    end
    checks++;
    if (flags_n !== 6'b100000) begin
      errors++; $display("FAIL raw_nofwd: got %b expected 100000", flags_n);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_instr(1, 2, 0, 0, 1, 0, 0, 0);
    cycle();
    set_instr(1, 0, 0, 2, 0, 0, 0, 0);
    cycle();
    set_instr(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (flags_f !== 6'b100000) begin
      errors++; $display("FAIL load_use: got %b expected 100000", flags_f);
    end
    pc_freeze = 1'b1;
    #1;
    checks++;
    if (ready_f !== 1'b0) begin
      errors++; $display("FAIL freeze_ready: got %b expected 0", ready_f);
    end
    cycle();
    pc_freeze = 1'b0;
    checks++;
    if (flags_f !== 6'b100010) begin
      errors++; $display("FAIL load_after_freeze: got %b expected 100010", flags_f);
    end
    checks++;
    if (flags_n !== 6'b100000) begin
      errors++; $display("FAIL load_after_freeze_nofwd: got %b expected 100000", flags_n);
    end
    cycle();
    checks++;
    if (flags_f !== 6'b000000) begin
      errors++; $display("FAIL load_drained: got %b expected 000000", flags_f);
    end
  endtask

  task automatic test_mispredict();
    do_reset();
    br_actual_taken = 1'b0;
    set_instr(1, 0, 1, 2, 0, 0, 1, 1);
    cycle();
    set_instr(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (flags_f !== 6'b001000) begin
      errors++; $display("FAIL branch_decoded: got %b expected 001000", flags_f);
    end
    cycle();
    checks++;
    if (flags_f !== 6'b000100) begin
      errors++; $display("FAIL branch_mispredict: got %b expected 000100", flags_f);
    end
    br_actual_taken = 1'b1;
    #1;
    checks++;
    if (flags_f !== 6'b000101) begin
      errors++; $display("FAIL branch_correct: got %b expected 000101", flags_f);
    end
    br_actual_taken = 1'b0;
    do_flush = 1'b1;
    cycle();
    do_flush = 1'b0;
    checks++;
    if (flags_f !== 6'b000000 || flush_f !== 4'd1) begin
      errors++;
      $display("FAIL flush: got flags %b count %0d expected 000000 count 1", flags_f, flush_f);
    end
  endtask

  task automatic test_structural();
    do_reset();
    set_instr(1, 0, 0, 0, 0, 1, 0, 0);
    cycle();
    set_instr(1, 4, 5, 6, 0, 0, 0, 0);
    cycle();
    checks++;
    if (flags_f !== 6'b000000) begin
      errors++; $display("FAIL str_gap: got %b expected 000000", flags_f);
    end
    set_instr(1, 1, 0, 0, 0, 1, 0, 0);
    cycle();
    set_instr(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (flags_f !== 6'b010000) begin
      errors++; $display("FAIL str_conflict: got %b expected 010000", flags_f);
    end
    cycle();
    checks++;
    if (flags_f !== 6'b000000) begin
      errors++; $display("FAIL str_cleared: got %b expected 000000", flags_f);
    end
  endtask

  task automatic test_counters();
    do_reset();
    for (int i = 0; i < 260; i++) begin
      set_instr(1, 0, 0, 0, 0, 0, 0, 0);
      cycle();
      if (i % 64 == 5) begin
        checks++;
        if (flags_f !== 6'b000000) begin
          errors++; $display("FAIL stream_flags: got %b expected 000000", flags_f);
        end
      end
    end
    set_instr(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle();
    checks++;
    if (retire_f !== 8'd4) begin
      errors++; $display("FAIL retire_wrap: got %0d expected 4", retire_f);
    end
    do_flush = 1'b1;
    for (int i = 0; i < 14; i++) cycle();
    checks++;
    if (flush_f !== 4'd14) begin
      errors++; $display("FAIL flush_count14: got %0d expected 14", flush_f);
    end
    cycle();
    cycle();
    do_flush = 1'b0;
    checks++;
    if (flush_f !== 4'd15) begin
      errors++; $display("FAIL flush_sat: got %0d expected 15", flush_f);
    end
  endtask

  task automatic test_random();
    logic [5:0] ef, en;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst_n           = ($urandom_range(0, 199) != 0);
      do_flush        = ($urandom_range(0, 11) == 0);
      pc_freeze       = ($urandom_range(0, 5) == 0);
      br_actual_taken = 1'($urandom_range(0, 1));
      resolved        = 1'($urandom_range(0, 1));
      set_instr($urandom_range(0, 4) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)));
      cycle();
      ef = exp_flags(1'b1);
      en = exp_flags(1'b0);
      checks++;
      if (flags_f !== ef || flags_n !== en) begin
        errors++;
        $display("FAIL rand_flags cyc %0d: got %b/%b expected %b/%b", i, flags_f, flags_n,
                 ef, en);
      end
      checks++;
      if (retire_f !== 8'(retired % 256) || flush_f !== 4'(flushes > 15 ? 15 : flushes)) begin
        errors++;
        $display("FAIL rand_counts cyc %0d: got %0d/%0d expected %0d/%0d", i, retire_f,
                 flush_f, retired % 256, flushes > 15 ? 15 : flushes);
      end
      checks++;
      if (ready_f !== !(pc_freeze || do_flush)) begin
        errors++;
        $display("FAIL rand_ready cyc %0d: got %b expected %b", i, ready_f,
                 !(pc_freeze || do_flush));
      end
    end
    rst_n = 1'b1;
    pc_freeze = 1'b0;
    do_flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    pc_freeze = 1'b0;
    do_flush = 1'b0;
    resolved = 1'b0;
    br_actual_taken = 1'b0;
    set_instr(0, 0, 0, 0, 0, 0, 0, 0);
    clear_model();
    #2;
    do_reset();
    test_reset();
    test_fwd_raw();
    test_load_use();
    test_mispredict();
    test_structural();
    test_counters();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
